priority_result_packer: RTL and testbench
=========================================

Name: priority_result_packer

Overview:
- Sits directly downstream of priority_encoder_4 and consumes its data_left/data_right/data_val outputs.
- Converts each valid one-hot left/right pair into a compact entry: zero flag, right index and left index.
- Packs PACK_N consecutive entries into one wide word for the next stage and emits it as a single-cycle valid pulse.
- Rejects malformed input pairs and counts them.

Parameters:
DATA_W, 4, width of the one-hot inputs (>=2); IDX_W = $clog2(DATA_W), ENTRY_W = 2*IDX_W+1
PACK_N, 4, entries per packed output word (>=2); CNT_W = $clog2(PACK_N+1)

Ports:
clk_150mhz_i  in  1  system clock, 150 MHz
rst_i  in  1  asynchronous active-high reset
data_left_i  in  DATA_W  one-hot of lowest set bit, or zero
data_right_i  in  DATA_W  one-hot of highest set bit, or zero
data_val_i  in  1  input beat valid
flush_i  in  1  emit a partial word if any entries are pending
packed_data_o  out  PACK_N*ENTRY_W  packed entries; slot k at bits [k*ENTRY_W +: ENTRY_W]
packed_cnt_o  out  CNT_W  number of valid slots in packed_data_o
packed_val_o  out  1  one-cycle pulse, packed word valid
onehot_err_o  out  1  one-cycle pulse, a beat was rejected
err_cnt_o  out  8  saturating count of rejected beats

Behaviour:
- Reset (asynchronous, rst_i=1): all outputs and the internal fill counter/slot buffer go to 0 immediately. Any partial word is discarded. Operation resumes on the first clock edge after rst_i deasserts.
- Entry format: bits [IDX_W-1:0] = left_idx, [2*IDX_W-1:IDX_W] = right_idx, [2*IDX_W] = zero.
  - zero=1 only when both inputs are all-zero; in that case both indices are 0.
- A beat (data_val_i=1) is valid when all of the following hold:
  - Each input is one-hot or all-zero.
  - Both inputs are zero, or both are non-zero.
  - left_idx <= right_idx.
- Otherwise the beat is rejected:
  - It is not stored and the fill count is unchanged.
  - onehot_err_o pulses on the next cycle.
  - err_cnt_o increments, saturating at 255.
- Valid beat: the entry is written to slot fill_cnt and fill_cnt increments.
  - If fill_cnt reaches PACK_N, then on the next cycle: packed_val_o=1, packed_cnt_o=PACK_N, packed_data_o=all slots, fill_cnt=0.
  - Latency is 1 cycle from the completing beat to packed_val_o.
- data_val_i=0: no state change. Gaps between beats are allowed and do not affect packing.
- flush_i=1 with fill_cnt>0: on the next cycle packed_val_o=1, packed_cnt_o=fill_cnt, unused slots are 0, and fill_cnt=0.
- flush_i=1 with fill_cnt=0 and no valid beat: no output.
- flush_i and a valid beat in the same cycle:
  - The beat is stored first, then the flush applies.
  - Exactly one packed_val_o pulse results, with count fill_cnt+1 (PACK_N if the word completes).
- flush_i and a rejected beat in the same cycle: the rejection and the flush both take effect.
- packed_data_o and packed_cnt_o hold their last values between pulses. packed_val_o and onehot_err_o are high for exactly one cycle per event.
- There is no backpressure. The consumer must accept every pulse, and back-to-back words (a pulse every PACK_N cycles) are supported.
- The slot buffer is cleared to 0 after each emission, so a partial word never carries stale entries.

Test Plan:
- Four consecutive valid beats (DATA_W=4, PACK_N=4): left/right = 0001/0100, 0010/1000, 0000/0000, 0100/0100 -> one cycle after the 4th beat: packed_val_o=1, packed_data_o=0x541A8, packed_cnt_o=4. No pulse on the other cycles.
- Same four beats with idle cycles between them -> identical single output, 1 cycle after the last beat.
- Two beats (0001/0100, 0010/1000), then flush_i -> next cycle: packed_data_o=0x001A8, packed_cnt_o=2. A following flush with nothing pending -> no pulse.
- Beats 0011/0100, 0100/0001 and 0000/0010 -> three onehot_err_o pulses, err_cnt_o=3, nothing stored. A following full word still packs correctly; 300 bad beats -> err_cnt_o=255.
- Three valid beats, then a 4th valid beat with flush_i=1 -> exactly one pulse with packed_cnt_o=4.
- Assert rst_i mid-clock after two stored beats -> outputs drop to 0 immediately. After release, four beats produce a word containing only the post-reset entries.

Source files
------------

// File: rtl/priority_result_packer.sv
// Packs validated one-hot left/right pairs into PACK_N-entry words; 1-cycle latency to packed_val_o.
// No backpressure: every packed/err pulse must be consumed the cycle it is presented.
module priority_result_packer #(
  parameter  int DATA_W  = 4,
  parameter  int PACK_N  = 4,
  localparam int IDX_W   = $clog2(DATA_W),
  localparam int ENTRY_W = 2*IDX_W+1,
  localparam int CNT_W   = $clog2(PACK_N+1)
) (
  input  logic                      clk_150mhz_i,
  input  logic                      rst_i,
  input  logic [DATA_W-1:0]         data_left_i,
  input  logic [DATA_W-1:0]         data_right_i,
  input  logic                      data_val_i,
  input  logic                      flush_i,
  output logic [PACK_N*ENTRY_W-1:0] packed_data_o,
  output logic [CNT_W-1:0]          packed_cnt_o,
  output logic                      packed_val_o,
  output logic                      onehot_err_o,
  output logic [7:0]                err_cnt_o
);

  function automatic logic [IDX_W-1:0] enc(input logic [DATA_W-1:0] v);
    enc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) enc = IDX_W'(i);
    end
  endfunction

  logic [CNT_W-1:0]          fill_q, fill_d;
  logic [PACK_N*ENTRY_W-1:0] slots_q, slots_d;
  logic [PACK_N*ENTRY_W-1:0] pdata_q, pdata_d;
  logic [CNT_W-1:0]          pcnt_q, pcnt_d;
  logic                      pval_q, pval_d;
  logic                      err_q, err_d;
  logic [7:0]                err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]   l_idx, r_idx;
  logic               l_nz, r_nz, l_oh, r_oh;
  logic               beat_ok, beat_bad, emit;
  logic [ENTRY_W-1:0] entry;
  logic [CNT_W-1:0]   fill_inc;

  always_comb begin
    l_idx    = enc(data_left_i);
    r_idx    = enc(data_right_i);
    l_nz     = |data_left_i;
    r_nz     = |data_right_i;
    l_oh     = (data_left_i & (data_left_i - DATA_W'(1))) == '0;
    r_oh     = (data_right_i & (data_right_i - DATA_W'(1))) == '0;
    beat_ok  = data_val_i && l_oh && r_oh && (l_nz == r_nz) && (l_idx <= r_idx);
    beat_bad = data_val_i && !beat_ok;
    entry    = {!l_nz, r_idx, l_idx};

    slots_d   = slots_q;
    pdata_d   = pdata_q;
    pcnt_d    = pcnt_q;
    pval_d    = 1'b0;
    err_d     = beat_bad;
    err_cnt_d = (beat_bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    for (int k = 0; k < PACK_N; k++) begin
      if (beat_ok && fill_q == CNT_W'(k)) slots_d[k*ENTRY_W +: ENTRY_W] = entry;
    end
    fill_inc = fill_q + CNT_W'(beat_ok);
    fill_d   = fill_inc;

    // The beat is folded in before the flush decision, so a flush with a beat emits once.
    emit = (fill_inc == CNT_W'(PACK_N)) || (flush_i && fill_inc != '0);
    if (emit) begin
      pdata_d = slots_d;
      pcnt_d  = fill_inc;
      pval_d  = 1'b1;
      slots_d = '0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk_150mhz_i or posedge rst_i) begin
    if (rst_i) begin
      fill_q    <= '0;
      slots_q   <= '0;
      pdata_q   <= '0;
      pcnt_q    <= '0;
      pval_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      fill_q    <= fill_d;
      slots_q   <= slots_d;
      pdata_q   <= pdata_d;
      pcnt_q    <= pcnt_d;
      pval_q    <= pval_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign packed_data_o = pdata_q;
  assign packed_cnt_o  = pcnt_q;
  assign packed_val_o  = pval_q;
  assign onehot_err_o  = err_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_priority_result_packer.sv
// Directed bench for priority_result_packer: expected packed words are queued when the
// completing stimulus is driven and checked when the pulse appears.
module tb_priority_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dl, dr;
  logic        dv, fl;
  logic [19:0] pdata;
  logic [2:0]  pcnt;
  logic        pval, oerr;
  logic [7:0]  ecnt;

  typedef struct {
    logic [19:0] d;
    logic [2:0]  c;
  } exp_t;
  exp_t exq[$];

  int total = 0;
  int bad   = 0;

  priority_result_packer #(.DATA_W(4), .PACK_N(4)) dut (
    .clk_150mhz_i (clk),
    .rst_i        (rst),
    .data_left_i  (dl),
    .data_right_i (dr),
    .data_val_i   (dv),
    .flush_i      (fl),
    .packed_data_o(pdata),
    .packed_cnt_o (pcnt),
    .packed_val_o (pval),
    .onehot_err_o (oerr),
    .err_cnt_o    (ecnt)
  );

  always #5 clk = ~clk;

  task automatic expect_word(input logic [19:0] d, input logic [2:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exq.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check the outputs it produced one edge later.
  task automatic step(input logic [3:0] l, input logic [3:0] r, input logic v,
                      input logic f, input logic exp_err);
    exp_t e;
    dl = l; dr = r; dv = v; fl = f;
    @(posedge clk);
    #1;
    dl = '0; dr = '0; dv = 1'b0; fl = 1'b0;
    chk("onehot_err", 32'(oerr), 32'(exp_err));
    if (exq.size() > 0) begin
      e = exq.pop_front();
      chk("packed_val", 32'(pval), 32'd1);
      chk("packed_data", 32'(pdata), 32'(e.d));
      chk("packed_cnt", 32'(pcnt), 32'(e.c));
    end else begin
      chk("packed_val_idle", 32'(pval), 32'd0);
    end
  endtask

  task automatic four_beats(input bit gaps, input bit flush_last);
    step(4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0);
    if (gaps) step('0, '0, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 4'b1000, 1'b1, 1'b0, 1'b0);
    if (gaps) begin
      step('0, '0, 1'b0, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0, 1'b0);
    end
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    if (gaps) step('0, '0, 1'b0, 1'b0, 1'b0);
    expect_word(20'h541A8, 3'd4);
    step(4'b0100, 4'b0100, 1'b1, flush_last, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dl = '0; dr = '0; dv = 1'b0; fl = 1'b0;
    #2;
    chk("rst_val", 32'(pval), 32'd0);
    chk("rst_data", 32'(pdata), 32'd0);
    chk("rst_cnt", 32'(pcnt), 32'd0);
    chk("rst_err", 32'(oerr), 32'd0);
    chk("rst_errcnt", 32'(ecnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back full word, then the same word with idle gaps
    four_beats(1'b0, 1'b0);
    four_beats(1'b1, 1'b0);

    // Partial word via flush, then an empty flush
    step(4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 4'b1000, 1'b1, 1'b0, 1'b0);
    expect_word(20'h001A8, 3'd2);
    step('0, '0, 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b0);

    // Malformed beats: not one-hot, left above right, zero mismatch
    step(4'b0011, 4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0100, 4'b0001, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1);
    chk("err_cnt_3", 32'(ecnt), 32'd3);
    four_beats(1'b0, 1'b0);

    // Flush coinciding with the completing beat yields a single pulse
    four_beats(1'b0, 1'b1);

    // Rejected beat plus flush: both take effect
    step(4'b0010, 4'b1000, 1'b1, 1'b0, 1'b0);
    expect_word(20'h0000D, 3'd1);
    step(4'b1000, 4'b0001, 1'b1, 1'b1, 1'b1);
    chk("err_cnt_4", 32'(ecnt), 32'd4);

    for (int i = 0; i < 300; i++) step(4'b0110, 4'b1000, 1'b1, 1'b0, 1'b1);
    chk("err_cnt_sat", 32'(ecnt), 32'd255);

    // Asynchronous reset mid-cycle with two entries pending
    step(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(pdata), 32'd0);
    chk("arst_cnt", 32'(pcnt), 32'd0);
    chk("arst_errcnt", 32'(ecnt), 32'd0);
    chk("arst_val", 32'(pval), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    four_beats(1'b0, 1'b0);
    chk("queue_drained", 32'(exq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
